m6809_pushpull_seq: RTL and testbench

- Sequencer for the 6809 register-move datapath during PSHS, PULS, PSHU and PULU (opcodes 0x34–0x37).
- Walks the post-byte register mask, issues one byte-wide memory cycle per register byte, and steers the register-file select and byte half.
- Returns the final stack-pointer value at the end.
- Started by the same pulse that loads the post-byte; sits between the instruction decoder, the register file and the bus interface.

---
 rtl/m6809_pushpull_seq.sv | 175 +++++++++++++++++
 tb/tb_m6809_pushpull_seq.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/m6809_pushpull_seq.sv
// Byte sequencer for 6809 PSHS/PULS/PSHU/PULU: walks the post-byte mask, one memory cycle per byte.
// Optional M6809_PP_CYCLE_EXACT_EN inserts 3 dead cycles after start to mimic the 6809 overhead.
module m6809_pushpull_seq #(
    parameter int unsigned ADDR_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        ir_in,
    input  logic [7:0]        din,
    input  logic [ADDR_W-1:0] sp_in,
    input  logic              mem_ack,
    output logic              busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [2:0]        reg_sel,
    output logic              byte_hi,
    output logic              reg_wr,
    output logic              use_u,
    output logic [ADDR_W-1:0] sp_out,
    output logic              sp_wr,
    output logic              done
);

    typedef enum logic [1:0] {
        StIdle,
        StXfer,
        StFin,
        StDead
    } state_e;

    localparam logic [ADDR_W-1:0] PtrOne = ADDR_W'(1);

    state_e            state_q, state_d;
    logic [7:0]        mask_q, mask_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              push_q, push_d;
    logic              use_u_q, use_u_d;
    logic              half_q, half_d;
    logic              req_q, req_d;
    logic              done_q, done_d;
`ifdef M6809_PP_CYCLE_EXACT_EN
    logic [1:0]        dead_q, dead_d;
`endif

    logic [2:0] sel;
    logic       is_wide;
    logic       hi;
    logic [7:0] mask_clr;
    logic       accept;

    // Push serves the highest set bit first, pull the lowest.
    always_comb begin
        sel = 3'd0;
        if (push_q) begin
            for (int i = 0; i < 8; i++) begin
                if (mask_q[i]) sel = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (mask_q[i]) sel = 3'(i);
            end
        end
    end

    assign is_wide  = sel[2];
    // Push moves low then high; pull moves high then low.
    assign hi       = is_wide & (half_q ^ ~push_q);
    assign mask_clr = mask_q & ~(8'b1 << sel);
    assign accept   = (state_q == StIdle) && start && (ir_in[7:2] == 6'b001101);

    always_comb begin
        state_d = state_q;
        mask_d  = mask_q;
        ptr_d   = ptr_q;
        push_d  = push_q;
        use_u_d = use_u_q;
        half_d  = half_q;
        req_d   = req_q;
        done_d  = 1'b0;
`ifdef M6809_PP_CYCLE_EXACT_EN
        dead_d  = dead_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    mask_d  = din;
                    ptr_d   = sp_in;
                    push_d  = ~ir_in[0];
                    use_u_d = ir_in[1];
                    half_d  = 1'b0;
                    req_d   = 1'b0;
`ifdef M6809_PP_CYCLE_EXACT_EN
                    dead_d  = 2'd2;
                    state_d = StDead;
`else
                    state_d = (din != 8'd0) ? StXfer : StFin;
`endif
                end
            end
            StXfer: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (mem_ack) begin
                    req_d = 1'b0;
                    ptr_d = push_q ? (ptr_q - PtrOne) : (ptr_q + PtrOne);
                    if (is_wide && !half_q) begin
                        half_d = 1'b1;
                    end else begin
                        half_d = 1'b0;
                        mask_d = mask_clr;
                        if (mask_clr == 8'd0) state_d = StFin;
                    end
                end
            end
            StFin: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
`ifdef M6809_PP_CYCLE_EXACT_EN
            StDead: begin
                if (dead_q == 2'd0) begin
                    state_d = (mask_q != 8'd0) ? StXfer : StFin;
                end else begin
                    dead_d = dead_q - 2'd1;
                end
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            mask_q  <= 8'd0;
            ptr_q   <= '0;
            push_q  <= 1'b0;
            use_u_q <= 1'b0;
            half_q  <= 1'b0;
            req_q   <= 1'b0;
            done_q  <= 1'b0;
`ifdef M6809_PP_CYCLE_EXACT_EN
            dead_q  <= 2'd0;
`endif
        end else begin
            state_q <= state_d;
            mask_q  <= mask_d;
            ptr_q   <= ptr_d;
            push_q  <= push_d;
            use_u_q <= use_u_d;
            half_q  <= half_d;
            req_q   <= req_d;
            done_q  <= done_d;
`ifdef M6809_PP_CYCLE_EXACT_EN
            dead_q  <= dead_d;
`endif
        end
    end

    // Request-side outputs are forced to zero outside a memory cycle.
    assign busy     = (state_q != StIdle);
    assign mem_req  = req_q;
    assign mem_we   = req_q & push_q;
    assign mem_addr = req_q ? (push_q ? (ptr_q - PtrOne) : ptr_q) : '0;
    assign reg_sel  = req_q ? sel : 3'd0;
    assign byte_hi  = req_q & hi;
    assign reg_wr   = req_q & mem_ack & ~push_q;
    assign use_u    = use_u_q & (busy | done_q);
    assign sp_out   = done_q ? ptr_q : '0;
    assign sp_wr    = done_q;
    assign done     = done_q;

endmodule

// File: tb/tb_m6809_pushpull_seq.sv
// Randomized bench for m6809_pushpull_seq against a byte-list model of the 6809 push/pull rules.
module tb_m6809_pushpull_seq;

    localparam int unsigned ADDR_W = 16;
`ifdef M6809_PP_CYCLE_EXACT_EN
    localparam int DeadCycles = 3;
`else
    localparam int DeadCycles = 0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [7:0]        ir_in;
    logic [7:0]        din;
    logic [ADDR_W-1:0] sp_in;
    logic              mem_ack;
    logic              busy;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [2:0]        reg_sel;
    logic              byte_hi;
    logic              reg_wr;
    logic              use_u;
    logic [ADDR_W-1:0] sp_out;
    logic              sp_wr;
    logic              done;

    m6809_pushpull_seq #(.ADDR_W(ADDR_W)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .ir_in    (ir_in),
        .din      (din),
        .sp_in    (sp_in),
        .mem_ack  (mem_ack),
        .busy     (busy),
        .mem_req  (mem_req),
        .mem_we   (mem_we),
        .mem_addr (mem_addr),
        .reg_sel  (reg_sel),
        .byte_hi  (byte_hi),
        .reg_wr   (reg_wr),
        .use_u    (use_u),
        .sp_out   (sp_out),
        .sp_wr    (sp_wr),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] addr;
        logic        we;
        logic [2:0]  sel;
        logic        hi;
    } xfer_t;

    xfer_t exp_q[$];
    int    n_checks = 0;
    int    n_errs   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One full instruction: model builds the byte list, then the bus is served cycle by cycle.
    task automatic run_op(input logic [7:0] ir, input logic [7:0] pb, input logic [15:0] sp,
                          input int dly_lo, input int dly_hi, input bit poke);
        logic [15:0] p;
        xfer_t       x;
        xfer_t       cur;
        int          dly[$];
        int          d;
        int          total;
        int          waited;
        int          cyc;
        bit          active;
        bit          fin;
        exp_q.delete();
        p = sp;
        if (!ir[0]) begin
            for (int b = 7; b >= 0; b--) begin
                if (pb[b]) begin
                    for (int h = 0; h < ((b >= 4) ? 2 : 1); h++) begin
                        p = p - 16'd1;
                        x.addr = p; x.we = 1'b1; x.sel = 3'(b); x.hi = (h == 1);
                        exp_q.push_back(x);
                    end
                end
            end
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (pb[b]) begin
                    for (int h = 0; h < ((b >= 4) ? 2 : 1); h++) begin
                        x.addr = p; x.we = 1'b0; x.sel = 3'(b); x.hi = (b >= 4) && (h == 0);
                        exp_q.push_back(x);
                        p = p + 16'd1;
                    end
                end
            end
        end
        total = 2 + DeadCycles;
        for (int i = 0; i < exp_q.size(); i++) begin
            d = $urandom_range(dly_hi, dly_lo);
            dly.push_back(d);
            total += 2 + d;
        end

        ir_in = ir; din = pb; sp_in = sp; start = 1'b1;
        step();
        cyc = 1; active = 1'b0; waited = 0; fin = 1'b0; d = 0;
        while (!fin && cyc <= total + 4) begin
            mem_ack = 1'b0;
            start   = 1'b0;
            ir_in   = 8'($urandom); din = 8'($urandom); sp_in = 16'($urandom);
            if (done) begin
                check("done_cycle", cyc, total);
                check("sp_out", sp_out, p);
                check("sp_wr", sp_wr, 1);
                check("busy_at_done", busy, 0);
                check("use_u_at_done", use_u, ir[1]);
                check("bytes_left", exp_q.size(), 0);
                fin = 1'b1;
            end else begin
                check("busy", busy, 1);
                check("reg_wr_idle", reg_wr, 0);
                if (mem_req) begin
                    if (!active) begin
                        if (exp_q.size() == 0) begin
                            check("extra_req", mem_req, 0);
                        end else begin
                            cur = exp_q.pop_front();
                            d = dly.pop_front();
                            active = 1'b1;
                            waited = 0;
                        end
                    end
                    if (active) begin
                        check("mem_addr", mem_addr, cur.addr);
                        check("mem_we", mem_we, cur.we);
                        check("reg_sel", reg_sel, cur.sel);
                        check("byte_hi", byte_hi, cur.hi);
                        check("use_u", use_u, ir[1]);
                        if (waited == d) begin
                            mem_ack = 1'b1;
                            #1;
                            check("reg_wr", reg_wr, !cur.we);
                            active = 1'b0;
                        end else begin
                            waited++;
                            if (poke && waited == 1) begin
                                start = 1'b1; ir_in = 8'h34; din = 8'hFF;
                            end
                        end
                    end
                end else if (active) begin
                    check("req_held", mem_req, 1);
                end
            end
            if (!fin) begin
                step();
                cyc++;
            end
        end
        mem_ack = 1'b0;
        start   = 1'b0;
        if (!fin) check("done_timeout", 0, 1);
    endtask

    task automatic check_quiet(input string tag, input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            step();
            check({tag, "_busy"}, busy, 0);
            check({tag, "_req"}, mem_req, 0);
            check({tag, "_done"}, done, 0);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ctl"}, {busy, mem_req, mem_we, reg_sel, byte_hi, reg_wr, use_u, sp_wr, done},
              0);
        check({tag, "_addr"}, {mem_addr, sp_out}, 0);
    endtask

    initial begin
        int guard;
        reset = 1'b1; start = 1'b0; mem_ack = 1'b0;
        ir_in = 8'h00; din = 8'h00; sp_in = '0;
        step();
        step();
        check_all_zero("reset");
        reset = 1'b0;
        step();

        run_op(8'h34, 8'hFF, 16'h1000, 0, 0, 1'b0);
        run_op(8'h35, 8'h81, 16'h0FF4, 0, 0, 1'b0);
        run_op(8'h36, 8'h01, 16'h0000, 0, 0, 1'b0);
        run_op(8'h37, 8'h40, 16'hFFFF, 0, 0, 1'b0);
        run_op(8'h34, 8'h00, 16'h1234, 0, 0, 1'b0);
        run_op(8'h37, 8'h00, 16'hABCD, 0, 0, 1'b0);

        ir_in = 8'h1F; din = 8'hFF; sp_in = 16'h2000; start = 1'b1;
        check_quiet("bad_1f", 4);
        start = 1'b1; ir_in = 8'h38;
        check_quiet("bad_38", 1);
        start = 1'b0;
        check_quiet("bad_tail", 3);

        run_op(8'h34, 8'h02, 16'h3000, 5, 5, 1'b1);

        for (int n = 0; n < 40; n++) begin
            run_op(8'h34 + 8'($urandom_range(3, 0)), 8'($urandom), 16'($urandom), 0, 3,
                   1'($urandom));
        end

        // Abort mid-transfer.
        ir_in = 8'h34; din = 8'hFF; sp_in = 16'h2000; start = 1'b1;
        step();
        start = 1'b0;
        guard = 0;
        while (!mem_req && guard < 10) begin
            step();
            guard++;
        end
        check("abort_req_seen", mem_req, 1);
        reset = 1'b1;
        step();
        check_all_zero("abort");
        reset = 1'b0;
        check_quiet("abort_after", 30);

        run_op(8'h35, 8'hF0, 16'h0002, 0, 2, 1'b0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
